// File: rtl/byte_window_framer.sv
// byte_window_framer: hunts for SYNC_BYTE at the oldest tap of an 8-byte
// shift register and emits one aligned 64-bit frame every 8 clocks.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   Q0..Q7          upstream taps, Q0 newest, Q7 oldest
//   word_out        captured frame, [63:56]=Q7 ... [7:0]=Q0
//   word_valid      word_out holds an unconsumed frame
//   word_ready      downstream accepts on word_valid && word_ready
//   locked          high while in LOCK
//   sync_err        one-cycle pulse per LOCK capture with a bad sync byte
//   overflow        sticky, set when a capture is dropped
//   word_csum       XOR of Q0..Q7 at capture (only with FRAMER_CHECKSUM_EN)
//
// Optional feature macro: FRAMER_CHECKSUM_EN adds the word_csum port.

module byte_window_framer #(
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
    parameter int unsigned MISS_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  Q0,
    input  logic [7:0]  Q1,
    input  logic [7:0]  Q2,
    input  logic [7:0]  Q3,
    input  logic [7:0]  Q4,
    input  logic [7:0]  Q5,
    input  logic [7:0]  Q6,
    input  logic [7:0]  Q7,
    output logic [63:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        locked,
    output logic        sync_err,
    output logic        overflow
`ifdef FRAMER_CHECKSUM_EN
    ,
    output logic [7:0]  word_csum
`endif
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        HUNT = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam logic [3:0] MISS_MAX = 4'(MISS_LIMIT);

    state_t     state, state_n;
    logic [2:0] fill_cnt, fill_cnt_n;
    logic       fill_done, fill_done_n;
    logic [2:0] phase, phase_n;
    logic [3:0] miss, miss_n;
    logic       capture;
    logic       sync_bad;
    logic       sync_ok;
    logic       accept;
    logic [63:0] frame;

    assign sync_ok = (Q7 == SYNC_BYTE);
    assign accept  = word_valid && word_ready;
    assign frame   = {Q7, Q6, Q5, Q4, Q3, Q2, Q1, Q0};
    assign locked  = (state == LOCK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FILL;
            fill_cnt  <= 3'd0;
            fill_done <= 1'b0;
            phase     <= 3'd0;
            miss      <= 4'd0;
        end else begin
            state     <= state_n;
            fill_cnt  <= fill_cnt_n;
            fill_done <= fill_done_n;
            phase     <= phase_n;
            miss      <= miss_n;
        end
    end

    always_comb begin
        state_n     = state;
        fill_cnt_n  = fill_cnt;
        fill_done_n = fill_done;
        phase_n     = phase;
        miss_n      = miss;
        capture     = 1'b0;
        sync_bad    = 1'b0;
        unique case (state)
            FILL: begin
                // Let the zeros left upstream by reset drain out first.
                fill_cnt_n = fill_cnt + 3'd1;
                if (fill_cnt == 3'd7) begin
                    fill_done_n = 1'b1;
                    state_n     = HUNT;
                end
            end
            HUNT: begin
                if (sync_ok) begin
                    capture = 1'b1;
                    state_n = LOCK;
                    phase_n = 3'd0;
                    miss_n  = 4'd0;
                end
            end
            LOCK: begin
                phase_n = phase + 3'd1;
                if (phase == 3'd7) begin
                    capture = 1'b1;
                    if (sync_ok) begin
                        miss_n = 4'd0;
                    end else begin
                        sync_bad = 1'b1;
                        if (miss + 4'd1 == MISS_MAX) begin
                            state_n = HUNT;
                            miss_n  = 4'd0;
                        end else begin
                            miss_n = miss + 4'd1;
                        end
                    end
                end
            end
            default: begin
                state_n = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_out   <= 64'h0;
            word_valid <= 1'b0;
            sync_err   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            sync_err <= sync_bad;
            if (capture) begin
                // A simultaneous accept frees the slot for the new frame.
                if (!word_valid || word_ready) begin
                    word_out   <= frame;
                    word_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (accept) begin
                word_valid <= 1'b0;
            end
        end
    end

`ifdef FRAMER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            word_csum <= 8'h00;
        end else if (capture && (!word_valid || word_ready)) begin
            word_csum <= Q0 ^ Q1 ^ Q2 ^ Q3 ^ Q4 ^ Q5 ^ Q6 ^ Q7;
        end
    end
`endif

endmodule
